// File: rtl/fifo_status_ctrl_mc_pkg.sv
// rtl/fifo_status_ctrl_mc_pkg.sv - shared constants, types and helpers for the FIFO request scheduler
package fifo_status_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_FSH  = 2'd3;

    localparam logic [31:0] MODE_LINE = "LINE";
    localparam logic [31:0] MODE_ONCE = "ONCE";

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } pick_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // First set bit of cand scanning ptr+1, ptr+2, ... wrapping at n; ptr itself is checked last.
    function automatic pick_t rr_pick(input logic [15:0] cand, input logic [3:0] ptr, input int n);
        pick_t p;
        int    k;
        p = '0;
        for (int j = 1; j <= 16; j++) begin
            if (j <= n && !p.hit) begin
                k = (int'(ptr) + j) % n;
                if (cand[k]) begin
                    p.hit = 1'b1;
                    p.idx = 4'(k);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/fifo_status_ctrl_mc_if.sv
// rtl/fifo_status_ctrl_mc_if.sv - burst request handshake between scheduler and AXI write master
interface fifo_status_ctrl_mc_if #(
    parameter int CHW   = 2,
    parameter int LSIZE = 9
);
    logic             req;
    logic             req_tail;
    logic [CHW-1:0]   req_ch;
    logic [LSIZE-1:0] req_len;
    logic             resp;
    logic             done;

    modport master (output req, req_tail, req_ch, req_len, input resp, done);
    modport slave  (input req, req_tail, req_ch, req_len, output resp, done);
endinterface

// File: rtl/fifo_status_ctrl_mc_tail_catch.sv
// rtl/fifo_status_ctrl_mc_tail_catch.sv - per-channel sticky tail-pending flag
module fifo_tail_catch (
    input  logic clock,
    input  logic rst_n,
    input  logic tail_i,
    input  logic clr_i,
    output logic pend_o
);
    logic pend_q, pend_d;

    // A new tail pulse beats a simultaneous clear so no end-of-line is lost.
    always_comb pend_d = tail_i | (pend_q & ~clr_i);

    // Pending flag register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) pend_q <= 1'b0;
        else        pend_q <= pend_d;
    end

    assign pend_o = pend_q;
endmodule

// File: rtl/fifo_status_ctrl_mc.sv
// rtl/fifo_status_ctrl_mc.sv - multi-channel FIFO-level burst request scheduler
module fifo_status_ctrl_mc
    import fifo_status_pkg::*;
#(
    parameter int          CH_NUM    = 4,
    parameter int          CW        = 10,
    parameter int          LSIZE     = 9,
    parameter int          THRESHOLD = 200,
    parameter int          BURST_LEN = 100,
    parameter logic [31:0] MODE      = MODE_LINE
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic [CH_NUM*CW-1:0]    count_i,
    input  logic [CH_NUM-1:0]       line_tail_i,
    input  logic [CH_NUM-1:0]       frame_tail_i,
    input  logic [CH_NUM*LSIZE-1:0] tail_len_i,
    input  logic [CH_NUM-1:0]       fifo_empty_i,
    fifo_status_ctrl_mc_if.master   req_if,
    output logic [CH_NUM-1:0]       burst_done_o,
    output logic [CH_NUM-1:0]       tail_done_o,
    output logic                    busy_o
);
    localparam int CHW = (CH_NUM > 1) ? clog2(CH_NUM) : 1;

    logic [CW-1:0]     count_a    [CH_NUM];
    logic [LSIZE-1:0]  tail_len_a [CH_NUM];
    logic [CH_NUM-1:0] tail_pulse, tail_pend, pend_clr;
    logic [CH_NUM-1:0] burst_exec_q, burst_exec_d;
    logic [1:0]        state_q, state_d;
    logic [CHW-1:0]    ch_q, ch_d, rr_q, rr_d;
    logic              tail_q, tail_d;
    logic [LSIZE-1:0]  len_q, len_d;
    pick_t             tail_pick, burst_pick;

    assign tail_pulse = (MODE == MODE_ONCE) ? frame_tail_i : line_tail_i;

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        assign count_a[gi]      = count_i[gi*CW +: CW];
        assign tail_len_a[gi]   = tail_len_i[gi*LSIZE +: LSIZE];
        assign burst_exec_d[gi] = count_a[gi] > CW'(THRESHOLD);
        // A pend on a drained channel has nothing to move; drop it silently while idle.
        assign pend_clr[gi] = ((state_q == ST_IDLE) && tail_pend[gi] && (count_a[gi] == '0) && fifo_empty_i[gi])
                            | ((state_q == ST_FSH) && tail_q && (ch_q == CHW'(gi)));
        fifo_tail_catch u_catch (
            .clock  (clock),
            .rst_n  (rst_n),
            .tail_i (tail_pulse[gi]),
            .clr_i  (pend_clr[gi]),
            .pend_o (tail_pend[gi])
        );
    end

    // Candidate selection: round-robin within tail and full-burst classes.
    always_comb begin
        tail_pick  = rr_pick(16'(tail_pend & ~fifo_empty_i), 4'(rr_q), CH_NUM);
        burst_pick = rr_pick(16'(burst_exec_q & ~fifo_empty_i), 4'(rr_q), CH_NUM);
    end

    // Arbiter next-state: grant in IDLE, handshake in REQ/WAIT, bookkeeping in FSH.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        tail_d  = tail_q;
        len_d   = len_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (tail_pick.hit) begin
                    ch_d    = CHW'(tail_pick.idx);
                    tail_d  = 1'b1;
                    len_d   = tail_len_a[ch_d];
                    state_d = ST_REQ;
                end else if (burst_pick.hit) begin
                    ch_d    = CHW'(burst_pick.idx);
                    tail_d  = 1'b0;
                    len_d   = LSIZE'(BURST_LEN);
                    state_d = ST_REQ;
                end
            end
            ST_REQ:  if (req_if.resp) state_d = req_if.done ? ST_FSH : ST_WAIT;
            ST_WAIT: if (req_if.done) state_d = ST_FSH;
            ST_FSH: begin
                rr_d    = ch_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter and request registers; ch/len/type only move on a grant.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            tail_q       <= 1'b0;
            len_q        <= '0;
            rr_q         <= '0;
            burst_exec_q <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            tail_q       <= tail_d;
            len_q        <= len_d;
            rr_q         <= rr_d;
            burst_exec_q <= burst_exec_d;
        end
    end

    // Completion pulses are the FSH state decoded onto the served channel.
    always_comb begin
        burst_done_o = '0;
        tail_done_o  = '0;
        if (state_q == ST_FSH) begin
            if (tail_q) tail_done_o[ch_q]  = 1'b1;
            else        burst_done_o[ch_q] = 1'b1;
        end
    end

    assign req_if.req      = (state_q == ST_REQ);
    assign req_if.req_tail = tail_q;
    assign req_if.req_ch   = ch_q;
    assign req_if.req_len  = len_q;
    assign busy_o          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fifo_status_ctrl_mc.sv
// tb/tb_fifo_status_ctrl_mc.sv - directed self-checking bench for fifo_status_ctrl_mc
module tb_fifo_status_ctrl_mc;
    import fifo_status_pkg::*;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [39:0] count, once_count;
    logic [3:0]  line_tail, frame_tail, fifo_empty, once_empty;
    logic [35:0] tail_len;
    logic [3:0]  bd_line, td_line, bd_once, td_once;
    logic        busy_line, busy_once;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clock = ~clock;

    fifo_status_ctrl_mc_if #(.CHW(2), .LSIZE(9)) if_line ();
    fifo_status_ctrl_mc_if #(.CHW(2), .LSIZE(9)) if_once ();

    fifo_status_ctrl_mc #(.MODE(MODE_LINE)) u_line (
        .clock(clock), .rst_n(rst_n), .count_i(count), .line_tail_i(line_tail),
        .frame_tail_i(frame_tail), .tail_len_i(tail_len), .fifo_empty_i(fifo_empty),
        .req_if(if_line.master), .burst_done_o(bd_line), .tail_done_o(td_line), .busy_o(busy_line)
    );

    fifo_status_ctrl_mc #(.MODE(MODE_ONCE)) u_once (
        .clock(clock), .rst_n(rst_n), .count_i(once_count), .line_tail_i(line_tail),
        .frame_tail_i(frame_tail), .tail_len_i(tail_len), .fifo_empty_i(once_empty),
        .req_if(if_once.master), .burst_done_o(bd_once), .tail_done_o(td_once), .busy_o(busy_once)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait for req, capture the request, answer with resp and done together; returns in FSH.
    task automatic serve(input bit once, output logic [1:0] ch, output logic tl, output logic [8:0] len);
        int n;
        n = 0;
        while (((once ? if_once.req : if_line.req) !== 1'b1) && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", once ? if_once.req : if_line.req, 1);
        ch  = once ? if_once.req_ch   : if_line.req_ch;
        tl  = once ? if_once.req_tail : if_line.req_tail;
        len = once ? if_once.req_len  : if_line.req_len;
        if (once) begin if_once.resp = 1'b1; if_once.done = 1'b1; end
        else      begin if_line.resp = 1'b1; if_line.done = 1'b1; end
        tick();
        if_once.resp = 1'b0; if_once.done = 1'b0;
        if_line.resp = 1'b0; if_line.done = 1'b0;
    endtask

    initial begin
        logic [1:0] ch, prev;
        logic       tl;
        logic [8:0] len;
        logic [3:0] acc;
        logic [1:0] t2_exp [4];
        int         n;

        t2_exp = '{2'd2, 2'd0, 2'd2, 2'd0};
        count = '0; once_count = '0; line_tail = '0; frame_tail = '0;
        fifo_empty = 4'hF; once_empty = 4'hF; tail_len = '0;
        if_line.resp = 1'b0; if_line.done = 1'b0;
        if_once.resp = 1'b0; if_once.done = 1'b0;
        prev = '0;

        tick(); tick();
        chk("rst_req", if_line.req, 0);
        chk("rst_busy", busy_line, 0);
        chk("rst_bd", bd_line, 0);
        chk("rst_td", td_line, 0);
        chk("rst_ch", if_line.req_ch, 0);
        chk("rst_len", if_line.req_len, 0);
        chk("rst_tail", if_line.req_tail, 0);
        rst_n = 1'b1;
        tick();

        // 1: single full burst on ch0
        count[9:0] = 10'd201; fifo_empty = 4'b1110;
        tick();
        chk("t1_lag", if_line.req, 0);
        tick();
        chk("t1_req", if_line.req, 1);
        chk("t1_ch", if_line.req_ch, 0);
        chk("t1_len", if_line.req_len, 100);
        chk("t1_tail", if_line.req_tail, 0);
        chk("t1_busy", busy_line, 1);
        if_line.resp = 1'b1;
        tick();
        if_line.resp = 1'b0;
        chk("t1_wait_req", if_line.req, 0);
        chk("t1_wait_busy", busy_line, 1);
        chk("t1_wait_bd", bd_line, 0);
        if_line.done = 1'b1;
        tick();
        if_line.done = 1'b0; count = '0; fifo_empty = 4'hF;
        chk("t1_bd", bd_line, 4'b0001);
        chk("t1_td", td_line, 0);
        tick();
        chk("t1_bd_1cyc", bd_line, 0);
        chk("t1_idle_busy", busy_line, 0);
        chk("t1_len_hold", if_line.req_len, 100);
        tick();
        chk("t1_no_regrant", if_line.req, 0);

        // 2: two full channels alternate (rr=0, so ch2 is first)
        count[9:0] = 10'd250; count[29:20] = 10'd250; fifo_empty = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            serve(1'b0, ch, tl, len);
            chk("t2_ch", ch, t2_exp[k]);
            chk("t2_bd", bd_line, 4'b0001 << t2_exp[k]);
            if (k > 0) chk("t2_norepeat", ch == prev, 0);
            prev = ch;
        end
        count = '0; fifo_empty = 4'hF;
        tick(); tick();

        // 3: tail on ch3 beats full burst on ch1
        count[19:10] = 10'd250; count[39:30] = 10'd5; fifo_empty = 4'b0101;
        tail_len[35:27] = 9'd37; line_tail = 4'b1000;
        tick();
        line_tail = '0;
        serve(1'b0, ch, tl, len);
        chk("t3_ch_a", ch, 3);
        chk("t3_tail_a", tl, 1);
        chk("t3_len_a", len, 37);
        chk("t3_td", td_line, 4'b1000);
        chk("t3_bd_a", bd_line, 0);
        serve(1'b0, ch, tl, len);
        chk("t3_ch_b", ch, 1);
        chk("t3_tail_b", tl, 0);
        chk("t3_len_b", len, 100);
        chk("t3_bd_b", bd_line, 4'b0010);
        count = '0; fifo_empty = 4'hF;
        tick(); tick();

        // 4: ONCE mode ignores line_tail, serves frame_tail
        once_count[9:0] = 10'd50; once_empty = 4'b1110;
        line_tail = 4'b0001;
        tick();
        line_tail = '0;
        tick(); tick(); tick(); tick();
        chk("t4_line_noreq", if_once.req, 0);
        chk("t4_line_nobusy", busy_once, 0);
        chk("t4_linedut_noreq", if_line.req, 0);
        tail_len[8:0] = 9'd55; frame_tail = 4'b0001;
        tick();
        frame_tail = '0;
        serve(1'b1, ch, tl, len);
        chk("t4_ch", ch, 0);
        chk("t4_tail", tl, 1);
        chk("t4_len", len, 55);
        chk("t4_td", td_once, 4'b0001);
        once_empty = 4'hF; once_count = '0;
        tick(); tick();

        // 5: tail on a drained channel is dropped silently
        line_tail = 4'b0100;
        tick();
        line_tail = '0;
        tick(); tick();
        chk("t5_noreq", if_line.req, 0);
        chk("t5_notd", td_line, 0);
        fifo_empty = 4'b1011; count[29:20] = 10'd10;
        tick(); tick(); tick(); tick();
        chk("t5_pend_cleared", if_line.req, 0);
        chk("t5_nobusy", busy_line, 0);
        fifo_empty = 4'hF; count = '0;
        tick();

        // 6: async reset in WAIT
        count[19:10] = 10'd250; fifo_empty = 4'b1101;
        n = 0;
        while (if_line.req !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t6_req", if_line.req, 1);
        if_line.resp = 1'b1;
        tick();
        if_line.resp = 1'b0;
        chk("t6_wait_busy", busy_line, 1);
        chk("t6_wait_req", if_line.req, 0);
        count[39:30] = 10'd5; fifo_empty = 4'b0101; line_tail = 4'b1000;
        tick();
        line_tail = '0;
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_req", if_line.req, 0);
        chk("t6_async_busy", busy_line, 0);
        count[19:10] = '0; fifo_empty = 4'b0111; if_line.done = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        acc = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if_line.done = 1'b0;
            acc = acc | bd_line | td_line;
        end
        chk("t6_no_pulse", acc, 0);
        chk("t6_pend_reset", if_line.req, 0);
        chk("t6_idle", busy_line, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
